// File: rtl/pkt_tx_assembler_if.sv
// Outgoing word stream from the packet assembler toward the radio/MAC.
// Master drives the word and framing flags; slave returns out_ready.
interface pkt_tx_assembler_if;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_sof;
  logic        out_eof;

  modport master (
    output out_data, out_valid, out_sof, out_eof,
    input  out_ready
  );

  modport slave (
    input  out_data, out_valid, out_sof, out_eof,
    output out_ready
  );
endinterface

// File: rtl/pkt_tx_assembler.sv
// EER-RL transmit packet assembler: snapshots node state on request and streams one
// packet as 16-bit words. Define TX_CHECKSUM_EN to append an XOR checksum word.
module pkt_tx_assembler (
  input  logic                 clk,
  input  logic                 nrst,
  input  logic                 tx_req,
  input  logic [2:0]           pkt_type,
  input  logic [15:0]          my_node_id,
  input  logic [15:0]          hops_from_sink,
  input  logic [15:0]          q_value,
  input  logic [15:0]          energy,
  input  logic [15:0]          e_max,
  input  logic [15:0]          e_min,
  input  logic [15:0]          e_threshold,
  input  logic [15:0]          dest_id,
  input  logic [15:0]          timeslot,
  input  logic [15:0]          payload,
  input  logic                 role,
  output logic                 tx_busy,
  output logic                 tx_done,
  output logic                 tx_err,
  pkt_tx_assembler_if.master   tx
);

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_DONE, S_ERR} state_t;

  state_t      state_q, state_d;
  logic [2:0]  idx_q, idx_d;
  logic [2:0]  last_q, last_d;
  logic [15:0] words_q [8];
  logic [15:0] words_d [8];

  logic [15:0] pkt_w [8];
  logic [2:0]  body_len;
  logic [2:0]  pkt_len;
  logic        req_ok;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Whole packet image built from the live inputs; captured only at acceptance.
  always_comb begin
    for (int i = 0; i < 8; i++) pkt_w[i] = '0;
    body_len = '0;
    req_ok   = 1'b1;
    case (pkt_type)
      3'b000: begin
        pkt_w[1] = my_node_id;  pkt_w[2] = sat_inc(hops_from_sink);
        pkt_w[3] = e_max;       pkt_w[4] = e_min;
        pkt_w[5] = e_threshold; body_len = 3'd5;
      end
      3'b001: begin
        pkt_w[1] = my_node_id; pkt_w[2] = q_value; pkt_w[3] = energy;
        body_len = 3'd3;       req_ok = role;
      end
      3'b010: begin
        pkt_w[1] = my_node_id; pkt_w[2] = dest_id;
        pkt_w[3] = energy;     pkt_w[4] = q_value; body_len = 3'd4;
      end
      3'b100: begin
        pkt_w[1] = my_node_id; pkt_w[2] = dest_id; pkt_w[3] = timeslot;
        body_len = 3'd3;       req_ok = role;
      end
      3'b101: begin
        pkt_w[1] = my_node_id; pkt_w[2] = dest_id;
        pkt_w[3] = energy;     pkt_w[4] = payload; body_len = 3'd4;
      end
      default: req_ok = 1'b0;
    endcase
`ifdef TX_CHECKSUM_EN
    pkt_len  = body_len + 3'd1;
    pkt_w[0] = {pkt_type, 5'b0, 5'b0, pkt_len};
    begin
      logic [15:0] csum;
      csum = '0;
      for (int i = 0; i < 8; i++) csum = csum ^ pkt_w[i];
      pkt_w[pkt_len] = csum;
    end
`else
    pkt_len  = body_len;
    pkt_w[0] = {pkt_type, 5'b0, 5'b0, pkt_len};
`endif
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    last_d  = last_q;
    words_d = words_q;
    case (state_q)
      S_IDLE: begin
        if (tx_req) begin
          words_d = pkt_w;
          last_d  = pkt_len;
          idx_d   = '0;
          state_d = req_ok ? S_SEND : S_ERR;
        end
      end
      S_SEND: begin
        if (tx.out_ready) begin
          if (idx_q == last_q) state_d = S_DONE;
          else                 idx_d   = idx_q + 3'd1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      last_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
    end
  end

  // Snapshot holds data only, so it is not reset.
  always_ff @(posedge clk) begin
    words_q <= words_d;
  end

  assign tx_busy      = (state_q != S_IDLE);
  assign tx_done      = (state_q == S_DONE);
  assign tx_err       = (state_q == S_ERR);
  assign tx.out_valid = (state_q == S_SEND);
  assign tx.out_data  = tx.out_valid ? words_q[idx_q] : 16'h0000;
  assign tx.out_sof   = tx.out_valid && (idx_q == 3'd0);
  assign tx.out_eof   = tx.out_valid && (idx_q == last_q);

endmodule

// File: tb/tb_pkt_tx_assembler.sv
// Directed bench for pkt_tx_assembler: vector table of packets plus backpressure
// and mid-packet reset sequences.
module tb_pkt_tx_assembler;
  logic        clk = 1'b0;
  logic        nrst;
  logic        tx_req;
  logic [2:0]  pkt_type;
  logic [15:0] my_node_id, hops_from_sink, q_value, energy;
  logic [15:0] e_max, e_min, e_threshold, dest_id, timeslot, payload;
  logic        role;
  logic        tx_busy, tx_done, tx_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pkt_tx_assembler_if tx ();

  pkt_tx_assembler dut (
    .clk(clk), .nrst(nrst), .tx_req(tx_req), .pkt_type(pkt_type),
    .my_node_id(my_node_id), .hops_from_sink(hops_from_sink), .q_value(q_value),
    .energy(energy), .e_max(e_max), .e_min(e_min), .e_threshold(e_threshold),
    .dest_id(dest_id), .timeslot(timeslot), .payload(payload), .role(role),
    .tx_busy(tx_busy), .tx_done(tx_done), .tx_err(tx_err), .tx(tx)
  );

  typedef struct {
    logic [2:0]         typ;
    logic               role;
    logic [15:0]        hops;
    logic [15:0]        dest;
    logic [15:0]        ts;
    logic [15:0]        pl;
    int                 n;
    logic [0:6][15:0]   w;
  } vec_t;

  vec_t vecs [10];

  function automatic vec_t mk(input logic [2:0] t, input logic r, input logic [15:0] h,
                              input logic [15:0] d, input logic [15:0] s, input logic [15:0] p,
                              input int n, input logic [0:6][15:0] w);
    vec_t v;
    v.typ = t; v.role = r; v.hops = h; v.dest = d; v.ts = s; v.pl = p; v.n = n; v.w = w;
    return v;
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%04h expected 0x%04h", name, act, exp);
    end
  endtask

  task automatic drive_common();
    my_node_id = 16'h000C; q_value = 16'h0123; energy = 16'h0800;
    e_max = 16'h1000; e_min = 16'h0100; e_threshold = 16'h0200;
  endtask

  task automatic scramble();
    pkt_type = 3'b111; my_node_id = 16'hDEAD; hops_from_sink = 16'h5555;
    q_value = 16'hAAAA; energy = 16'h1111; e_max = 16'h2222; e_min = 16'h3333;
    e_threshold = 16'h4444; dest_id = 16'h6666; timeslot = 16'h7777;
    payload = 16'h8888; role = ~role;
  endtask

  task automatic run_vec(input vec_t v, input int k);
    logic [0:6][15:0] w;
    int n;
    w = v.w;
    n = v.n;
`ifdef TX_CHECKSUM_EN
    if (n > 0) begin
      logic [15:0] x;
      w[0] = w[0] + 16'd1;
      x = '0;
      for (int i = 0; i < n; i++) x = x ^ w[i];
      w[n] = x;
      n++;
    end
`endif
    @(negedge clk);
    drive_common();
    pkt_type = v.typ; role = v.role; hops_from_sink = v.hops;
    dest_id = v.dest; timeslot = v.ts; payload = v.pl;
    tx.out_ready = 1'b1;
    tx_req = 1'b1;
    @(posedge clk);
    @(negedge clk);
    tx_req = 1'b0;
    scramble();
    if (n == 0) begin
      chk($sformatf("v%0d err_pulse", k), {15'b0, tx_err}, 16'h1);
      chk($sformatf("v%0d err_no_valid", k), {15'b0, tx.out_valid}, 16'h0);
      chk($sformatf("v%0d err_busy", k), {15'b0, tx_busy}, 16'h1);
      @(negedge clk);
      chk($sformatf("v%0d err_end", k), {13'b0, tx_err, tx_busy, tx.out_valid}, 16'h0);
    end else begin
      for (int i = 0; i < n; i++) begin
        if (i > 0) @(negedge clk);
        chk($sformatf("v%0d w%0d data", k, i), tx.out_data, w[i]);
        chk($sformatf("v%0d w%0d flags", k, i),
            {12'b0, tx.out_valid, tx.out_sof, tx.out_eof, tx_busy},
            {12'b0, 1'b1, (i == 0), (i == n - 1), 1'b1});
      end
      @(negedge clk);
      chk($sformatf("v%0d done", k), {14'b0, tx_done, tx.out_valid}, 16'h2);
      chk($sformatf("v%0d idle_data", k), tx.out_data, 16'h0000);
      @(negedge clk);
      chk($sformatf("v%0d after_done", k), {14'b0, tx_done, tx_busy}, 16'h0);
    end
  endtask

  initial begin
    vecs[0] = mk(3'b000, 1'b0, 16'h0003, 16'h0000, 16'h0000, 16'h0000, 6,
                 {16'h0005, 16'h000C, 16'h0004, 16'h1000, 16'h0100, 16'h0200, 16'h0});
    vecs[1] = mk(3'b001, 1'b1, 16'h0003, 16'h0000, 16'h0000, 16'h0000, 4,
                 {16'h2003, 16'h000C, 16'h0123, 16'h0800, 16'h0, 16'h0, 16'h0});
    vecs[2] = mk(3'b010, 1'b0, 16'h0003, 16'h0007, 16'h0000, 16'h0000, 5,
                 {16'h4004, 16'h000C, 16'h0007, 16'h0800, 16'h0123, 16'h0, 16'h0});
    vecs[3] = mk(3'b100, 1'b1, 16'h0003, 16'h0021, 16'h0005, 16'h0000, 4,
                 {16'h8003, 16'h000C, 16'h0021, 16'h0005, 16'h0, 16'h0, 16'h0});
    vecs[4] = mk(3'b101, 1'b0, 16'h0003, 16'h0007, 16'h0000, 16'hBEEF, 5,
                 {16'hA004, 16'h000C, 16'h0007, 16'h0800, 16'hBEEF, 16'h0, 16'h0});
    vecs[5] = mk(3'b000, 1'b0, 16'hFFFF, 16'h0000, 16'h0000, 16'h0000, 6,
                 {16'h0005, 16'h000C, 16'hFFFF, 16'h1000, 16'h0100, 16'h0200, 16'h0});
    vecs[6] = mk(3'b011, 1'b1, 16'h0003, 16'h0007, 16'h0000, 16'h0000, 0, '0);
    vecs[7] = mk(3'b100, 1'b0, 16'h0003, 16'h0021, 16'h0005, 16'h0000, 0, '0);
    vecs[8] = mk(3'b001, 1'b0, 16'h0003, 16'h0000, 16'h0000, 16'h0000, 0, '0);
    vecs[9] = mk(3'b110, 1'b1, 16'h0003, 16'h0000, 16'h0000, 16'h0000, 0, '0);

    nrst = 1'b0; tx_req = 1'b0; tx.out_ready = 1'b0;
    pkt_type = '0; role = 1'b0; hops_from_sink = '0; dest_id = '0;
    timeslot = '0; payload = '0;
    drive_common();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset data", tx.out_data, 16'h0000);
    chk("reset flags", {10'b0, tx.out_valid, tx.out_sof, tx.out_eof, tx_busy, tx_done, tx_err},
        16'h0);
    nrst = 1'b1;
    tx.out_ready = 1'b1;
    @(negedge clk);
    chk("idle ready no effect", {14'b0, tx.out_valid, tx_busy}, 16'h0);

    for (int k = 0; k < 10; k++) run_vec(vecs[k], k);

`ifdef TX_CHECKSUM_EN
    // Heartbeat with checksum against hand-computed words.
    @(negedge clk);
    drive_common(); pkt_type = 3'b000; hops_from_sink = 16'h0003; tx_req = 1'b1;
    @(posedge clk);
    @(negedge clk);
    tx_req = 1'b0;
    chk("hb_cs header", tx.out_data, 16'h0006);
    repeat (6) @(negedge clk);
    chk("hb_cs checksum", tx.out_data, 16'h130E);
    chk("hb_cs eof", {15'b0, tx.out_eof}, 16'h1);
    repeat (2) @(negedge clk);
`endif

    // Backpressure: CH announce, sink stalls three cycles on the source-ID word.
    @(negedge clk);
    drive_common(); pkt_type = 3'b001; role = 1'b1; tx.out_ready = 1'b1; tx_req = 1'b1;
    @(posedge clk);
    @(negedge clk);
    tx_req = 1'b0;
`ifdef TX_CHECKSUM_EN
    chk("bp header", tx.out_data, 16'h2004);
`else
    chk("bp header", tx.out_data, 16'h2003);
`endif
    @(negedge clk);
    tx.out_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      if (c > 0) @(negedge clk);
      if (c == 3) tx.out_ready = 1'b1;
      chk($sformatf("bp hold%0d data", c), tx.out_data, 16'h000C);
      chk($sformatf("bp hold%0d flags", c), {13'b0, tx.out_valid, tx.out_sof, tx.out_eof},
          16'h4);
    end
    @(negedge clk);
    chk("bp w3", tx.out_data, 16'h0123);
    @(negedge clk);
    chk("bp w4", tx.out_data, 16'h0800);
`ifdef TX_CHECKSUM_EN
    chk("bp w4 eof", {15'b0, tx.out_eof}, 16'h0);
    @(negedge clk);
    chk("bp checksum", tx.out_data, 16'h292B);
`endif
    chk("bp last eof", {15'b0, tx.out_eof}, 16'h1);
    @(negedge clk);
    chk("bp done", {15'b0, tx_done}, 16'h1);
    @(negedge clk);

    // Abort: reset asserted while the third word of a data packet is on the bus.
    @(negedge clk);
    drive_common(); pkt_type = 3'b101; role = 1'b0; dest_id = 16'h0007; payload = 16'hBEEF;
    tx.out_ready = 1'b1; tx_req = 1'b1;
    @(posedge clk);
    @(negedge clk);
    tx_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("abort w3", tx.out_data, 16'h0007);
    nrst = 1'b0;
    @(negedge clk);
    chk("abort state", {13'b0, tx.out_valid, tx_busy, tx_done}, 16'h0);
    chk("abort data", tx.out_data, 16'h0000);
    @(negedge clk);
    chk("abort no done", {15'b0, tx_done}, 16'h0);
    nrst = 1'b1;
    run_vec(vecs[4], 10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pkt_tx_assembler.md
# pkt_tx_assembler

Transmit-side packet assembler for the EER-RL node. It takes a transmit request from the node controller and snapshots the node's own state: ID, hops, Q-value, energy and cluster info. It then serialises one outgoing packet as a stream of 16-bit words over a valid/ready interface toward the radio/MAC. It produces the same packet types that the receive path decodes: heartbeat, CH announce, join, timeslot and data.

## Interface
- No parameters. Word width fixed at 16.
- `clk`  in  1  clock
- `nrst`  in  1  reset, synchronous, active-low
- `tx_req`  in  1  request; accepted only while `tx_busy`=0
- `pkt_type`  in  3  000 HB, 001 CH announce, 010 join, 100 timeslot, 101 data
- `my_node_id`  in  16  source ID
- `hops_from_sink`  in  16  own hop count
- `q_value`  in  16  own Q-value
- `energy`  in  16  residual energy
- `e_max`, `e_min`, `e_threshold`  in  16 each  heartbeat energy fields
- `dest_id`  in  16  destination (CH or member ID)
- `timeslot`  in  16  assigned slot
- `payload`  in  16  data word
- `role`  in  1  1 = this node is CH
- `tx_busy`  out  1  high from the acceptance edge until return to IDLE
- `out_data`  out  16  current word
- `out_valid`  out  1  word valid
- `out_ready`  in  1  sink accepts word
- `out_sof`  out  1  high with the header word
- `out_eof`  out  1  high with the last word
- `tx_done`  out  1  one-cycle pulse after the last handshake
- `tx_err`  out  1  one-cycle pulse on a rejected request

## Operation
- States:
  - IDLE: on `tx_req` at an edge, latch all inputs. Invalid request → ERR. Otherwise → SEND with word index 0.
  - SEND: present word[idx] with `out_valid`=1. On `out_valid && out_ready`, idx+1. The handshake on the last word → DONE.
  - DONE: `tx_done`=1 for one cycle → IDLE.
  - ERR: `tx_err`=1 for one cycle → IDLE.
- Invalid requests: types 011, 110, 111; or type 001 or 100 with latched `role`=0.
- Header word is {type[2:0], 5'b0, len[7:0]}. `len` is the number of words after the header.
- Bodies, in order:
  - HB: src, hops+1, e_max, e_min, e_threshold (len 5).
  - CH: src, q_value, energy (3).
  - join: src, dest_id, energy, q_value (4).
  - timeslot: src, dest_id, timeslot (3).
  - data: src, dest_id, energy, payload (4).
- hops+1 saturates: 0xFFFF stays 0xFFFF.
- All words come from the snapshot. Input changes after acceptance have no effect.
- `out_data` and the sof/eof flags stay stable while `out_valid`=1 and `out_ready`=0.
- `out_data` is 0 whenever `out_valid`=0.

## Timing
- Reset: every output is 0, and the state is IDLE.
- nrst low mid-packet aborts the packet at that edge. No `tx_done` pulse is generated.
- Latency: request accepted at edge N → header valid in cycle N+1.
- One word per cycle when `out_ready` is held high. A packet of L words finishes in L cycles, then one DONE cycle.
- `tx_req` sampled during SEND, DONE or ERR is ignored and not queued. The controller must hold `tx_req` until it sees `tx_busy`=1.
- A request present in the DONE cycle is not taken. The earliest next acceptance is the edge ending the first IDLE cycle.
- `out_ready` high while `out_valid`=0 has no effect.

## Configuration
- `TX_CHECKSUM_EN` defined:
  - One extra final word is appended: the XOR of all preceding words, header included.
  - `len` includes this word (HB len 6).
  - `out_eof` moves to the checksum word.
- `TX_CHECKSUM_EN` undefined: no checksum word, and `len` is as listed above.

## Test plan
- HB, no checksum. Inputs: id 0x000C, hops 3, e_max 0x1000, e_min 0x0100, e_thr 0x0200, ready=1. Expected words 0x0005, 0x000C, 0x0004, 0x1000, 0x0100, 0x0200; sof on word 1, eof on word 6; `tx_done` the next cycle.
- Same HB with `TX_CHECKSUM_EN`. Expected header 0x0006 and final word 0x130E.
- Backpressure. CH announce with role=1, `out_ready` low for 3 cycles on word 2. Word 2 (0x000C) is held stable for 4 cycles, then the stream continues; header 0x2003.
- Rejections. Type 011 → `tx_err` pulse, no `out_valid`. Type 100 with role=0 → same.
- hops_from_sink 0xFFFF in a heartbeat → hops word is 0xFFFF.
- Abort. nrst low during word 3 of a data packet → `out_valid`=0 and `tx_busy`=0 after the edge, no `tx_done`. The next request sends a complete packet.
